// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, the NOP and HALT encodings, the fetch
// state type and a saturating increment used by event counters.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == {WORD_W{1'b1}}) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline slot register carrying {valid, pc, pc_plus1, instr}.
// Used as the IF/ID register and intended for reuse as ID/EX.
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : load d_* when high (drive with ~stall)
//   flush            : synchronous clear to an empty slot, wins over en
//   d_valid/pc/pc_plus1/instr : slot contents to load
//   q_valid/pc/pc_plus1/instr : registered slot contents
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_plus1,
    input  logic [31:0] d_instr,
    output logic        q_valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc_plus1,
    output logic [31:0] q_instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_pc       <= 32'h0;
            q_pc_plus1 <= 32'h0;
            q_instr    <= NOP_INSTR;
        end else if (flush) begin
            q_valid    <= 1'b0;
            q_pc       <= 32'h0;
            q_pc_plus1 <= 32'h0;
            q_instr    <= NOP_INSTR;
        end else if (en) begin
            q_valid    <= d_valid;
            q_pc       <= d_pc;
            q_pc_plus1 <= d_pc_plus1;
            q_instr    <= d_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the word-addressed PC, presents it to the
// instruction memory and captures the returned word into the IF/ID slot.
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall_i               : hold PC and IF/ID
//   redirect_valid_i/target_i : taken branch/jump, flushes the slot
//   imem_addr_o / imem_instr_i : instruction memory address / read data
//   if_valid_o, if_pc_o, if_pc_plus1_o, if_instr_o : IF/ID slot
//   halted_o              : fetch stopped on HALT_INSTR
//   fetch_count_o         : delivered instructions, saturating
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = cpu_pkg::HALT_INSTR,
    parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus1_o,
    output logic [31:0] if_instr_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    import cpu_pkg::*;

    fetch_state_t state_p0, state_n;
    logic [31:0]  pc_p0, pc_n;
    logic [31:0]  cnt_p0, cnt_n;
    logic         slot_flush;
    logic         slot_en;

    // ---- stage 0: PC, next-PC selection, fetch FSM ----
    // Priority: redirect > stall > halt > advance.
    always_comb begin
        pc_n    = pc_p0;
        state_n = state_p0;
        cnt_n   = cnt_p0;
        if (redirect_valid_i) begin
            pc_n    = redirect_target_i;
            state_n = RUN;
        end else if (stall_i) begin
            pc_n    = pc_p0;
        end else if (state_p0 == HALTED) begin
            pc_n    = pc_p0;
        end else begin
            cnt_n = sat_inc(cnt_p0);
            if (imem_instr_i == HALT_INSTR) begin
                state_n = HALTED;
            end else begin
                pc_n = pc_p0 + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0    <= RESET_PC;
            state_p0 <= RUN;
            cnt_p0   <= 32'h0;
        end else begin
            pc_p0    <= pc_n;
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
        end
    end

    // A redirect discards the wrong-path slot; once halted, the halt word is
    // shown for one unstalled cycle and then replaced by a bubble.
    assign slot_flush = redirect_valid_i | ((state_p0 == HALTED) & ~stall_i);
    assign slot_en    = ~stall_i;

    // ---- stage 1: IF/ID register ----
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (slot_en),
        .flush      (slot_flush),
        .d_valid    (1'b1),
        .d_pc       (pc_p0),
        .d_pc_plus1 (pc_p0 + 32'd1),
        .d_instr    (imem_instr_i),
        .q_valid    (if_valid_o),
        .q_pc       (if_pc_o),
        .q_pc_plus1 (if_pc_plus1_o),
        .q_instr    (if_instr_o)
    );

    assign imem_addr_o   = pc_p0;
    assign halted_o      = (state_p0 == HALTED);
    assign fetch_count_o = cnt_p0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into an IF/ID pipeline register for decode. It supports stall, branch/jump redirect with flush, and halt detection.

Parameters:
RESET_PC, 32'h0000_0000, word address fetched first after reset
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch once latched
NOP_INSTR, 32'h0000_0000, value held in if_instr when the slot is invalid

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  decode not accepting; hold PC and IF/ID
redirect_valid_i  in  1  branch/jump taken; overrides the sequential PC
redirect_target_i  in  32  word address of the redirect target
imem_addr_o  out  32  word address to instruction memory, equals pc
imem_instr_i  in  32  combinational read data for imem_addr_o
if_valid_o  out  1  IF/ID slot holds a real instruction
if_pc_o  out  32  word address of if_instr_o
if_pc_plus1_o  out  32  if_pc_o + 1, link value for jal-type instructions
if_instr_o  out  32  latched instruction
halted_o  out  1  fetch stopped on HALT_INSTR
fetch_count_o  out  32  number of instructions delivered, saturating

Behaviour:
- Addressing is by word. The PC advances by 1 per instruction, not by 4. Memory aliases on its low address bits; this block does not check range. The PC wraps modulo 2^32.
- Reset, asynchronous: pc=RESET_PC, state=RUN, if_valid_o=0, if_pc_o=0, if_pc_plus1_o=0, if_instr_o=NOP_INSTR, halted_o=0, fetch_count_o=0.
- imem_addr_o=pc, combinational. Latency: the instruction at pc appears on if_instr_o on the next rising edge.
- Update priority each edge is redirect > stall > halt > advance.
- Redirect (redirect_valid_i=1), in any state:
  - pc<=redirect_target_i
  - if_valid_o<=0, if_instr_o<=NOP_INSTR (flush the wrong-path slot)
  - state<=RUN
- Stall (stall_i=1, no redirect): pc and the whole IF/ID register hold unchanged. fetch_count_o holds.
- RUN, no stall, no redirect:
  - if_instr_o<=imem_instr_i, if_pc_o<=pc, if_pc_plus1_o<=pc+1, if_valid_o<=1
  - fetch_count_o<=fetch_count_o+1, saturating at 32'hFFFF_FFFF
  - If imem_instr_i==HALT_INSTR: state<=HALTED and pc holds. Otherwise pc<=pc+1.
- HALTED:
  - halted_o=1, registered together with the state.
  - The halt instruction is delivered once with if_valid_o=1. On the next non-stalled edge, if_valid_o<=0 and if_instr_o<=NOP_INSTR.
  - pc frozen, counter frozen.
  - Only a redirect or reset leaves HALTED. This covers a halt fetched on a wrong path.
- Stall while HALTED holds the halt instruction in the slot. Redirect while stalled is still taken.
- Reset mid-operation discards the IF/ID contents immediately, with no drain.

Decomposition:
- Shared package cpu_pkg: WORD_W=32, NOP_INSTR, HALT_INSTR, fetch state enum {RUN, HALTED}.
- Sub-module if_id_reg: a register with enable (~stall) and synchronous flush, carrying {valid, pc, pc_plus1, instr}. Reused later for the ID/EX register.
- PC, next-PC mux, FSM and counter stay in fetch_unit.

Test Plan:
- Reset and sequential fetch: rst_n low, then memory words 0..3 = 11,22,33,44 → imem_addr_o 0,1,2,3 on successive cycles; if_instr_o 11,22,33 with if_pc_o 0,1,2 one cycle later; if_valid_o=0 during reset, and fetch_count_o=3 after three edges.
- Stall: stall_i=1 for 2 cycles while if_pc_o=1 → imem_addr_o stays 2, if_instr_o stays 22, count unchanged; after release the next if_pc_o=2.
- Redirect with flush, and redirect beating stall: redirect_valid_i=1, target=0x40 with stall_i=1 → next edge if_valid_o=0 and imem_addr_o=0x40; the following edge if_pc_o=0x40 and if_pc_plus1_o=0x41.
- Halt: word 5=HALT_INSTR → if_instr_o=FFFFFFFF valid for one cycle, then if_valid_o=0 and halted_o=1; imem_addr_o stays 5 for 10 cycles and count is frozen.
- Halt escape: in HALTED, redirect to 0x10 → halted_o=0 and fetch resumes at 0x10, 0x11.
- Async reset mid-run: rst_n low between edges at pc=7 → outputs return to reset values immediately, without waiting for clk; after release fetch restarts at RESET_PC.
